// File: rtl/mmc3_irq_sched_pkg.sv
// Shared encodings for the MMC3 scanline IRQ scheduler: register selects,
// savestate field selects and the A12 qualifier states.
package mmc3_irq_pkg;

    typedef enum logic [1:0] {
        REG_LATCH   = 2'd0,
        REG_RELOAD  = 2'd1,
        REG_DISABLE = 2'd2,
        REG_ENABLE  = 2'd3
    } reg_sel_e;

    typedef enum logic [1:0] {
        SS_LATCH   = 2'd0,
        SS_ENABLE  = 2'd1,
        SS_COUNTER = 2'd2,
        SS_PENDING = 2'd3
    } ss_sel_e;

    typedef enum logic [1:0] {
        Q_LOW     = 2'd0,
        Q_HIGH    = 2'd1,
        Q_HIGH_NQ = 2'd2
    } q_state_e;

endpackage

// File: rtl/mmc3_irq_sched_a12_qualifier.sv
// Synchronises M2 and PPU A12, deglitches A12 and emits a one-clk tick for
// each A12 rise that followed enough M2 falls with A12 low.
module a12_qualifier
    import mmc3_irq_pkg::*;
#(
    parameter int unsigned MIN_LOW_M2 = 3,
    parameter int unsigned DG_LEN     = 2
) (
    input  logic clk,
    input  logic map_rst,
    input  logic m2,
    input  logic ppu_a12,
    input  logic ss_act,
    output logic a12_tick
);

    localparam int unsigned DGW = $clog2(DG_LEN + 1);

    logic           m2_s1, m2_s2, m2_d;
    logic           a12_s1, a12_s2, a12f;
    logic [DGW-1:0] dg_cnt;
    logic [3:0]     low_cnt;
    logic           m2_fall;
    logic           tick_raw;
    q_state_e       state, state_nxt;

    assign m2_fall = m2_d & ~m2_s2;

    always_ff @(posedge clk) begin
        if (map_rst) begin
            m2_s1  <= 1'b0;
            m2_s2  <= 1'b0;
            m2_d   <= 1'b0;
            a12_s1 <= 1'b0;
            a12_s2 <= 1'b0;
            a12f   <= 1'b0;
            dg_cnt <= '0;
        end else begin
            m2_s1  <= m2;
            m2_s2  <= m2_s1;
            m2_d   <= m2_s2;
            a12_s1 <= ppu_a12;
            a12_s2 <= a12_s1;
            // Filtered level follows only after DG_LEN consecutive differing samples.
            if (a12_s2 == a12f) begin
                dg_cnt <= '0;
            end else if (dg_cnt == DGW'(DG_LEN - 1)) begin
                a12f   <= a12_s2;
                dg_cnt <= '0;
            end else begin
                dg_cnt <= dg_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            state   <= Q_LOW;
            low_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != Q_LOW) begin
                low_cnt <= '0;
            end else if (m2_fall && (low_cnt != 4'hF)) begin
                low_cnt <= low_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tick_raw  = 1'b0;
        case (state)
            Q_LOW: begin
                if (a12f) begin
                    tick_raw  = (low_cnt >= 4'(MIN_LOW_M2));
                    state_nxt = tick_raw ? Q_HIGH : Q_HIGH_NQ;
                end
            end
            Q_HIGH, Q_HIGH_NQ: begin
                if (!a12f) state_nxt = Q_LOW;
            end
            default: state_nxt = Q_LOW;
        endcase
    end

    assign a12_tick = tick_raw & ~ss_act;

endmodule

// File: rtl/mmc3_irq_sched.sv
// MMC3 scanline IRQ counter on a single clock: qualified A12 ticks, CPU
// register writes and savestate access, resolved by a fixed priority.
module mmc3_irq_sched
    import mmc3_irq_pkg::*;
#(
    parameter int unsigned MIN_LOW_M2 = 3,
    parameter int unsigned DG_LEN     = 2
) (
    input  logic       clk,
    input  logic       map_rst,
    input  logic       m2,
    input  logic       ppu_a12,
    input  logic       mmc3a,
    input  logic       reg_we,
    input  logic [1:0] reg_sel,
    input  logic [7:0] reg_dat,
    input  logic       ss_we,
    input  logic [1:0] ss_sel,
    input  logic [7:0] ss_din,
    input  logic       ss_act,
    output logic [7:0] ss_dout,
    output logic       irq,
    output logic [7:0] irq_ctr,
    output logic       a12_tick
);

    logic [7:0] latch, ctr, step_next;
    logic       enable, reload_req;
    logic       trig, reload_wr, ack_wr, do_step;

    a12_qualifier #(
        .MIN_LOW_M2(MIN_LOW_M2),
        .DG_LEN    (DG_LEN)
    ) u_qual (
        .clk     (clk),
        .map_rst (map_rst),
        .m2      (m2),
        .ppu_a12 (ppu_a12),
        .ss_act  (ss_act),
        .a12_tick(a12_tick)
    );

    always_comb begin
        step_next = ((ctr == 8'd0) || reload_req) ? latch : ctr - 8'd1;
        trig      = mmc3a ? ((step_next == 8'd0) && ((ctr != 8'd0) || reload_req))
                          : (step_next == 8'd0);
        reload_wr = reg_we && (reg_sel == REG_RELOAD);
        ack_wr    = reg_we && (reg_sel == REG_DISABLE);
        do_step   = a12_tick && !reload_wr;
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            latch      <= '0;
            ctr        <= '0;
            enable     <= 1'b0;
            irq        <= 1'b0;
            reload_req <= 1'b0;
        end else if (ss_we) begin
            case (ss_sel)
                SS_LATCH:   latch  <= ss_din;
                SS_ENABLE:  enable <= ss_din[0];
                SS_COUNTER: ctr    <= ss_din;
                SS_PENDING: irq    <= ss_din[0];
                default:    ;
            endcase
        end else begin
            if (reg_we) begin
                case (reg_sel)
                    REG_LATCH:   latch <= reg_dat;
                    REG_RELOAD: begin
                        ctr        <= '0;
                        reload_req <= 1'b1;
                    end
                    REG_DISABLE: begin
                        enable <= 1'b0;
                        irq    <= 1'b0;
                    end
                    REG_ENABLE:  enable <= 1'b1;
                    default:     ;
                endcase
            end
            // Step uses pre-write latch/enable; an acknowledge in the same clk suppresses the trigger.
            if (do_step) begin
                ctr        <= step_next;
                reload_req <= 1'b0;
                if (trig && enable && !ack_wr) irq <= 1'b1;
            end
        end
    end

    always_comb begin
        ss_dout = '0;
        case (ss_sel)
            SS_LATCH:   ss_dout = latch;
            SS_ENABLE:  ss_dout = {7'd0, enable};
            SS_COUNTER: ss_dout = ctr;
            SS_PENDING: ss_dout = {7'd0, irq};
            default:    ss_dout = '0;
        endcase
    end

    assign irq_ctr = ctr;

endmodule
